pia_bus_arbiter: RTL
====================

Name: pia_bus_arbiter

Overview:
- Shares the single PIA register port (strobe / write-enable / 7-bit address / 8-bit data) between two requesters: the 6502 CPU core and the debug/OSD host channel.
- The CPU has priority. Debug accesses take idle CPU cycles, or are forced in after a bounded starvation window, with the CPU stalled through its RDY-style stall line.
- Sits between the CPU bus decode and the PIA instance in the console top level.

Parameters:
- STARVE_MAX, 4: max consecutive CPU-granted cycles while a debug request is pending before debug is forced; legal range 1..255.
- AW, 7: address width of the PIA register port.

Ports:
- clk_i  in  1  system clock; all logic on rising edge
- rst_ni  in  1  reset, asynchronous assert, active-low
- cpu_stb_i  in  1  CPU access request to PIA, valid for one cycle unless stalled
- cpu_we_i  in  1  CPU write enable
- cpu_adr_i  in  AW  CPU register address
- cpu_dat_i  in  8  CPU write data
- cpu_dat_o  out  8  CPU read data, combinational copy of pia_dat_i
- cpu_stall_o  out  1  CPU access not granted this cycle; CPU holds stb/we/adr/dat
- dbg_req_i  in  1  debug access request, level, held until dbg_ack_o
- dbg_we_i  in  1  debug write enable
- dbg_adr_i  in  AW  debug register address
- dbg_dat_i  in  8  debug write data
- dbg_ack_o  out  1  one-cycle pulse: debug access complete
- dbg_dat_o  out  8  debug read data, registered, valid with dbg_ack_o
- pia_stb_o  out  1  strobe to PIA
- pia_we_o  out  1  write enable to PIA
- pia_adr_o  out  AW  address to PIA
- pia_dat_o  out  8  write data to PIA
- pia_dat_i  in  8  PIA read data, registered in the PIA, valid the cycle after a read strobe
- gnt_dbg_o  out  1  debug owns the PIA port this cycle (diagnostic)

Behaviour:
- Reset (rst_ni=0, async): state IDLE, starvation counter 0.
  - Outputs at reset: dbg_ack_o=0, dbg_dat_o=0, cpu_stall_o=0, pia_stb_o=0, gnt_dbg_o=0.
  - A debug access in flight when reset asserts is dropped; no ack is issued after release, and the requester re-issues.
- States: IDLE, DBG_RESP.
  - Grant is decided combinationally each cycle from the state, the requests and the starvation counter.
  - pia_* outputs are a combinational mux of the granted requester's bus; all zero when nothing is granted.
- Grant rules in IDLE:
  - Debug granted when dbg_req_i=1 and either cpu_stb_i=0 or counter==STARVE_MAX.
  - Otherwise the CPU is granted when cpu_stb_i=1.
  - Debug grant with cpu_stb_i=1 drives cpu_stall_o=1 for that cycle.
  - A debug grant drives gnt_dbg_o=1, pia_stb_o=1 and pia_we_o=dbg_we_i. Next state is DBG_RESP and the counter clears.
- Grant rule in DBG_RESP:
  - The CPU is granted unconditionally and cpu_stall_o=0; the debug request is ignored.
  - Next cycle: dbg_ack_o=1. dbg_dat_o captures pia_dat_i on a read and is unchanged on a write.
  - Next state is IDLE.
- Handshake timing:
  - Debug access strobed in cycle N; ack in cycle N+1.
  - The requester drops or changes its request in N+1, and it is sampled again from N+2. Minimum debug issue interval is 2 cycles.
- Starvation counter:
  - Increments on each CPU-granted cycle while dbg_req_i=1; saturates at STARVE_MAX.
  - Clears on a debug grant and whenever dbg_req_i=0.
  - Width is ceil(log2(STARVE_MAX+1)).
- CPU read data: cpu_dat_o = pia_dat_i always. The CPU samples it the cycle after its granted read strobe, unchanged from the direct connection.
  - A stalled CPU cycle produces no PIA strobe; the CPU retries the same access the next cycle.
- Read side effects (INTIM underflow clear, INSTAT clear) apply to debug reads exactly as to CPU reads; the arbiter does not filter them.
- Simultaneous requests with counter < STARVE_MAX: the CPU wins, debug waits, and the counter increments.
- No combinational path from dbg_req_i to cpu_dat_o.

Test Plan:
- Reset: hold rst_ni=0 mid-stream -> all outputs 0 asynchronously. After release, first cpu_stb_i read of adr 0x04 -> pia_stb_o=1, pia_adr_o=0x04, cpu_stall_o=0.
- Idle debug read: cpu_stb_i=0, dbg_req_i=1, dbg_adr_i=0x04, PIA returns 0x5A -> pia_stb_o=1 in N, gnt_dbg_o=1; dbg_ack_o=1, dbg_dat_o=0x5A in N+1.
- Starvation, STARVE_MAX=4: cpu_stb_i=1 continuously, debug write adr 0x16 data 0x20 pending.
  - Expected: CPU granted 4 cycles, debug granted on the 5th with cpu_stall_o=1 and pia_dat_o=0x20, pia_we_o=1.
  - Then the CPU is granted in the ack cycle; dbg_dat_o is unchanged.
- Back-to-back debug: dbg_req_i held high through the ack -> second strobe no earlier than N+2, and DBG_RESP never grants debug.
- Reset mid-operation: assert rst_ni=0 in cycle N of a debug read -> no dbg_ack_o after release, counter 0, state IDLE.
- Random traffic: random CPU/debug mix against a PIA model for 10k cycles -> no cycle with two grants, every debug request acked, no debug wait longer than STARVE_MAX+1 cycles.

Source files
------------

// File: rtl/pia_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : pia_bus_arbiter
//  Description : Shares the PIA register port between the 6502 CPU (priority)
//                and the debug/OSD host channel. Debug takes idle CPU cycles
//                or is forced in after a bounded starvation window while the
//                CPU is stalled.
//  Revision    : 1.0 - initial release
// ============================================================================
module pia_bus_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int AW         = 7
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cpu_stb_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_adr_i,
  input  logic [7:0]    cpu_dat_i,
  output logic [7:0]    cpu_dat_o,
  output logic          cpu_stall_o,
  input  logic          dbg_req_i,
  input  logic          dbg_we_i,
  input  logic [AW-1:0] dbg_adr_i,
  input  logic [7:0]    dbg_dat_i,
  output logic          dbg_ack_o,
  output logic [7:0]    dbg_dat_o,
  output logic          pia_stb_o,
  output logic          pia_we_o,
  output logic [AW-1:0] pia_adr_o,
  output logic [7:0]    pia_dat_o,
  input  logic [7:0]    pia_dat_i,
  output logic          gnt_dbg_o
);

  localparam int            CW           = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] C_STARVE_MAX = CW'(STARVE_MAX);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    DBG_RESP = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_dbg_we;
  logic [7:0]    r_dbg_dat;
  logic          w_dbg_gnt;
  logic          w_cpu_gnt;
  logic          w_dbg_rd_resp;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant decision and next state; reset gates every grant so the PIA port
  // stays quiet while rst_ni is low even though the port mux is combinational
  always_comb begin
    w_dbg_gnt   = 1'b0;
    w_cpu_gnt   = 1'b0;
    w_state_nxt = IDLE;
    if (rst_ni) begin
      case (r_state)
        IDLE: begin
          if (dbg_req_i && (!cpu_stb_i || (r_cnt == C_STARVE_MAX))) begin
            w_dbg_gnt   = 1'b1;
            w_state_nxt = DBG_RESP;
          end else begin
            w_cpu_gnt = cpu_stb_i;
          end
        end
        DBG_RESP: begin
          // The pending debug request is the one being acknowledged now
          w_cpu_gnt   = cpu_stb_i;
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Starvation counter next value: counts CPU wins while debug waits
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_dbg_gnt || !dbg_req_i) begin
      w_cnt_nxt = '0;
    end else if (w_cpu_gnt && (r_cnt != C_STARVE_MAX)) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  // Starvation counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  // Remember the debug direction for the response cycle and keep the last
  // debug read value once the response cycle has passed
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_dbg_we  <= 1'b0;
      r_dbg_dat <= 8'h00;
    end else begin
      if (w_dbg_gnt) begin
        r_dbg_we <= dbg_we_i;
      end
      if (w_dbg_rd_resp) begin
        r_dbg_dat <= pia_dat_i;
      end
    end
  end

  // The PIA returns read data the cycle after the strobe, which is the ack
  // cycle; it is passed through then and held from the register afterwards
  assign w_dbg_rd_resp = (r_state == DBG_RESP) && !r_dbg_we;
  assign dbg_ack_o     = (r_state == DBG_RESP);
  assign dbg_dat_o     = w_dbg_rd_resp ? pia_dat_i : r_dbg_dat;

  // PIA port mux of the granted requester, zero when idle
  always_comb begin
    pia_stb_o = w_dbg_gnt | w_cpu_gnt;
    pia_we_o  = 1'b0;
    pia_adr_o = '0;
    pia_dat_o = 8'h00;
    if (w_dbg_gnt) begin
      pia_we_o  = dbg_we_i;
      pia_adr_o = dbg_adr_i;
      pia_dat_o = dbg_dat_i;
    end else if (w_cpu_gnt) begin
      pia_we_o  = cpu_we_i;
      pia_adr_o = cpu_adr_i;
      pia_dat_o = cpu_dat_i;
    end
  end

  assign cpu_stall_o = w_dbg_gnt & cpu_stb_i;
  assign gnt_dbg_o   = w_dbg_gnt;
  assign cpu_dat_o   = pia_dat_i;

endmodule
`default_nettype wire
